// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch unit: PC source selects,
// fetch FSM states and the NOP instruction word.
package fetch_pkg;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_JMP = 2'b01;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/pc_reg.sv
// Program counter with branch-condition write enable and next-PC mux.
// Updates every cycle independently of the fetch state.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        beq_cond,
  input  logic        bnq_cond,
  input  logic [1:0]  pc_src,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic [11:0] jmp_field,
  output logic [15:0] pc
);

  logic        pc_we;
  logic [15:0] pc_d;

  // Both conditional enables high means "branch either way": always taken.
  assign pc_we = pc_write | (beq_cond & alu_zero) | (bnq_cond & ~alu_zero);

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    pc_d = pc;
    if (pc_we) begin
      case (pc_src)
        PCSRC_ALU: pc_d = alu_result;
        PCSRC_JMP: pc_d = {pc[15:12], jmp_field};
        default:   pc_d = pc;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_d;
  end

endmodule : pc_reg

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, two-state fetch FSM and IR.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        PCBEqCond,
  input  logic        PCBNqCond,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  func_field,
  output logic [15:0] pc,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be within 1..255");
  end

  fetch_state_t state_q, state_d;
  logic [15:0]  addr_q;
  logic         timeout_hit;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .pc_write   (PCWrite),
    .beq_cond   (PCBEqCond),
    .bnq_cond   (PCBNqCond),
    .pc_src     (PCSrc),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .jmp_field  (ir[11:0]),
    .pc         (pc)
  );

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic       err_q;

  // An ack in the last counted cycle takes priority over the abort.
  assign timeout_hit = (state_q == ST_WAIT) && !imem_ack &&
                       (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= 8'd0;
    end else if (state_q == ST_WAIT && state_d == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_q <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= timeout_hit;
  end

  assign fetch_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (IRWrite) state_d = ST_WAIT;
      ST_WAIT: if (imem_ack || timeout_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Address is captured from the pre-update pc, so a same-cycle PC write is not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= RESET_PC;
      ir         <= NOP_INSTR;
      fetch_done <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      if (state_q == ST_IDLE && IRWrite) begin
        addr_q <= pc;
      end
      if (state_q == ST_WAIT && imem_ack) begin
        ir         <= imem_rdata;
        fetch_done <= 1'b1;
      end else if (timeout_hit) begin
        ir         <= NOP_INSTR;
        fetch_done <= 1'b1;
      end
    end
  end

  assign imem_req   = (state_q == ST_WAIT);
  assign fetch_busy = (state_q == ST_WAIT);
  assign imem_addr  = addr_q;
  assign opcode     = ir[15:12];
  assign func_field = ir[3:0];

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC-update vector table, hand-written
// fetch/reset sequences and a randomized run against a transaction-level model.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int          TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        IRWrite, PCWrite, PCBEqCond, PCBNqCond, alu_zero, imem_ack;
  logic [1:0]  PCSrc;
  logic [15:0] alu_result, imem_rdata;
  logic        imem_req, fetch_busy, fetch_done, fetch_err;
  logic [15:0] imem_addr, ir, pc;
  logic [3:0]  opcode, func_field;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCBEqCond(PCBEqCond), .PCBNqCond(PCBNqCond), .PCSrc(PCSrc),
    .alu_result(alu_result), .alu_zero(alu_zero), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
    .ir(ir), .opcode(opcode), .func_field(func_field), .pc(pc),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] pc0;
    logic        wr, beq, bnq;
    logic [1:0]  src;
    logic [15:0] alu;
    logic        z;
    logic [15:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vecs[10];

  // Reference state: a fetch is either pending (with its address and age) or not.
  logic [15:0] m_pc, m_ir, m_addr;
  bit          m_busy, m_done, m_err;
  int          m_waited;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IRWrite = 0; PCWrite = 0; PCBEqCond = 0; PCBNqCond = 0; PCSrc = 2'b00;
    alu_result = 16'h0000; alu_zero = 0; imem_rdata = 16'h0000; imem_ack = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle_inputs();
    @(negedge clk);
    rst = 1;
    #1;
  endtask

  task automatic do_fetch(input logic [15:0] data, input int k);
    IRWrite = 1;
    step();
    IRWrite = 0;
    for (int i = 1; i < k; i++) step();
    imem_ack = 1; imem_rdata = data;
    step();
    imem_ack = 0;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_ir = 16'h0000; m_addr = RESET_PC;
    m_busy = 0; m_done = 0; m_err = 0; m_waited = 0;
  endtask

  // One clock edge of architectural behaviour, from the inputs currently driven.
  task automatic model_edge();
    logic        we;
    logic [15:0] n_pc;
    we   = PCWrite | (PCBEqCond & alu_zero) | (PCBNqCond & ~alu_zero);
    n_pc = m_pc;
    if (we && PCSrc == 2'b00) n_pc = alu_result;
    if (we && PCSrc == 2'b01) n_pc = {m_pc[15:12], m_ir[11:0]};
    m_done = 0;
    m_err  = 0;
    if (!m_busy) begin
      if (IRWrite) begin
        m_busy = 1; m_addr = m_pc; m_waited = 0;
      end
    end else begin
      m_waited++;
      if (imem_ack) begin
        m_ir = imem_rdata; m_done = 1; m_busy = 0;
      end
`ifdef FETCH_TIMEOUT_EN
      else if (m_waited == TIMEOUT) begin
        m_ir = 16'h0000; m_done = 1; m_err = 1; m_busy = 0;
      end
`endif
    end
    m_pc = n_pc;
  endtask

  initial begin
    int done_cnt;
    rst = 0;
    idle_inputs();

    // Reset state while rst is held low
    #3;
    check("rst_pc", pc, RESET_PC);
    check("rst_ir", ir, 16'h0000);
    check("rst_req", 16'(imem_req), 16'h0);
    check("rst_busy", 16'(fetch_busy), 16'h0);
    check("rst_done", 16'(fetch_done), 16'h0);
    check("rst_err", 16'(fetch_err), 16'h0);
    check("rst_addr", imem_addr, RESET_PC);
    #9 rst = 1;

    // Basic fetch with ack on the third WAIT cycle
    IRWrite = 1;
    step();
    IRWrite = 0;
    done_cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      check("wait_req", 16'(imem_req), 16'h1);
      check("wait_busy", 16'(fetch_busy), 16'h1);
      check("wait_addr", imem_addr, 16'h0000);
      if (fetch_done) done_cnt++;
      if (i == 3) begin imem_ack = 1; imem_rdata = 16'h8123; end
      step();
    end
    imem_ack = 0;
    if (fetch_done) done_cnt++;
    check("f1_ir", ir, 16'h8123);
    check("f1_opcode", 16'(opcode), 16'h8);
    check("f1_func", 16'(func_field), 16'h3);
    check("f1_req_off", 16'(imem_req), 16'h0);
    step();
    if (fetch_done) done_cnt++;
    check("f1_done_pulses", 16'(done_cnt), 16'd1);

    // Ack while idle is ignored
    imem_ack = 1; imem_rdata = 16'h5555;
    step();
    imem_ack = 0;
    check("idle_ack_ir", ir, 16'h8123);
    check("idle_ack_done", 16'(fetch_done), 16'h0);

    // Load ir = 3ABC for the jump rows of the PC table
    do_fetch(16'h3ABC, 1);
    check("f2_ir", ir, 16'h3ABC);
    check("f2_done", 16'(fetch_done), 16'h1);

    vecs[0] = '{"beq_taken",  16'h0010, 0, 1, 0, 2'b00, 16'h0044, 1, 16'h0044};
    vecs[1] = '{"beq_not",    16'h0010, 0, 1, 0, 2'b00, 16'h0044, 0, 16'h0010};
    vecs[2] = '{"bnq_taken",  16'h0010, 0, 0, 1, 2'b00, 16'h0044, 0, 16'h0044};
    vecs[3] = '{"bnq_not",    16'h0010, 0, 0, 1, 2'b00, 16'h0044, 1, 16'h0010};
    vecs[4] = '{"both_cond",  16'h0010, 0, 1, 1, 2'b00, 16'h0044, 0, 16'h0044};
    vecs[5] = '{"jmp",        16'h3000, 1, 0, 0, 2'b01, 16'h0044, 0, 16'h3ABC};
    vecs[6] = '{"src10_hold", 16'h3000, 1, 0, 0, 2'b10, 16'h0044, 0, 16'h3000};
    vecs[7] = '{"src11_hold", 16'h3000, 1, 0, 0, 2'b11, 16'h0044, 1, 16'h3000};
    vecs[8] = '{"no_we",      16'h3000, 0, 0, 0, 2'b00, 16'h1234, 1, 16'h3000};
    vecs[9] = '{"wr_alu",     16'h7000, 1, 0, 0, 2'b00, 16'hFFFF, 0, 16'hFFFF};

    foreach (vecs[i]) begin
      PCWrite = 1; PCSrc = 2'b00; alu_result = vecs[i].pc0;
      step();
      PCWrite = vecs[i].wr; PCBEqCond = vecs[i].beq; PCBNqCond = vecs[i].bnq;
      PCSrc = vecs[i].src; alu_result = vecs[i].alu; alu_zero = vecs[i].z;
      step();
      check(vecs[i].name, pc, vecs[i].exp_pc);
      idle_inputs();
    end

    // IRWrite and PCWrite together: address uses the old pc; IRWrite in WAIT is ignored
    do_reset();
    IRWrite = 1; PCWrite = 1; PCSrc = 2'b00; alu_result = 16'h0002;
    step();
    PCWrite = 0;
    check("same_cyc_addr", imem_addr, 16'h0000);
    check("same_cyc_pc", pc, 16'h0002);
    check("same_cyc_req", 16'(imem_req), 16'h1);
    step();
    IRWrite = 0;
    check("wait_irw_addr", imem_addr, 16'h0000);
    imem_ack = 1; imem_rdata = 16'h1111;
    step();
    imem_ack = 0;
    check("wait_irw_ir", ir, 16'h1111);
    check("no_extra_req", 16'(imem_req), 16'h0);
    step();
    check("no_extra_req2", 16'(imem_req), 16'h0);

`ifdef FETCH_TIMEOUT_EN
    // Timeout without ack
    imem_rdata = 16'hDEAD;
    IRWrite = 1;
    step();
    IRWrite = 0;
    for (int i = 1; i < TIMEOUT; i++) step();
    check("to_busy_last", 16'(fetch_busy), 16'h1);
    step();
    check("to_ir", ir, 16'h0000);
    check("to_done", 16'(fetch_done), 16'h1);
    check("to_err", 16'(fetch_err), 16'h1);
    check("to_idle", 16'(fetch_busy), 16'h0);
    step();
    check("to_err_pulse", 16'(fetch_err), 16'h0);
    // Ack in the final counted cycle wins
    IRWrite = 1;
    step();
    IRWrite = 0;
    for (int i = 1; i < TIMEOUT; i++) step();
    imem_ack = 1; imem_rdata = 16'hABCD;
    step();
    imem_ack = 0;
    check("to_ack_ir", ir, 16'hABCD);
    check("to_ack_done", 16'(fetch_done), 16'h1);
    check("to_ack_err", 16'(fetch_err), 16'h0);
`endif

    // Reset asserted mid-WAIT, late ack afterwards
    do_reset();
    IRWrite = 1; PCWrite = 1; alu_result = 16'h0777;
    step();
    IRWrite = 0; PCWrite = 0;
    check("pre_rst_req", 16'(imem_req), 16'h1);
    check("pre_rst_pc", pc, 16'h0777);
    #2 rst = 0;
    #1;
    check("async_rst_req", 16'(imem_req), 16'h0);
    check("async_rst_pc", pc, RESET_PC);
    @(negedge clk);
    rst = 1;
    imem_ack = 1; imem_rdata = 16'hBEEF;
    step();
    imem_ack = 0;
    check("late_ack_ir", ir, 16'h0000);
    check("late_ack_done", 16'(fetch_done), 16'h0);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      IRWrite    = ($urandom_range(3) == 0);
      PCWrite    = ($urandom_range(4) == 0);
      PCBEqCond  = ($urandom_range(5) == 0);
      PCBNqCond  = ($urandom_range(5) == 0);
      PCSrc      = 2'($urandom_range(3));
      alu_result = 16'($urandom);
      alu_zero   = 1'($urandom);
      imem_rdata = 16'($urandom);
      imem_ack   = ($urandom_range(3) == 0);
      model_edge();
      step();
      check("rnd_pc", pc, m_pc);
      check("rnd_ir", ir, m_ir);
      check("rnd_req", 16'(imem_req), 16'(m_busy));
      check("rnd_addr", imem_addr, m_addr);
      check("rnd_done", 16'(fetch_done), 16'(m_done));
      check("rnd_err", 16'(fetch_err), 16'(m_err));
      check("rnd_fields", {opcode, 8'h00, func_field}, {m_ir[15:12], 8'h00, m_ir[3:0]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum number of WAIT cycles before a fetch is aborted (used only with FETCH_TIMEOUT_EN).
REQ-003 SHALL have ports, in this order:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  reset, asynchronous, active-low.
- IRWrite  in  1  fetch request from the controller.
- PCWrite  in  1  unconditional PC write enable.
- PCBEqCond  in  1  PC write enable when alu_zero=1.
- PCBNqCond  in  1  PC write enable when alu_zero=0.
- PCSrc  in  2  next-PC source select.
- alu_result  in  16  ALU output.
- alu_zero  in  1  ALU zero flag.
- imem_rdata  in  16  instruction read data.
- imem_ack  in  1  instruction memory ready.
- imem_req  out  1  instruction memory request.
- imem_addr  out  16  instruction address.
- ir  out  16  instruction register.
- opcode  out  4  ir[15:12].
- func_field  out  4  ir[3:0].
- pc  out  16  program counter.
- fetch_busy  out  1  high while in state WAIT.
- fetch_done  out  1  one-cycle pulse marking a new ir value.
- fetch_err  out  1  one-cycle pulse marking an aborted fetch.

Function
REQ-004 SHALL compute pc_we = PCWrite | (PCBEqCond & alu_zero) | (PCBNqCond & ~alu_zero); with both Cond inputs high, pc_we=1 regardless of alu_zero.
REQ-005 On pc_we, SHALL load pc with: PCSrc=00 -> alu_result; PCSrc=01 -> {pc[15:12], ir[11:0]}; PCSrc=10/11 -> pc unchanged.
REQ-006 PC update SHALL be independent of fetch state; pc may change in any state.
REQ-007 FSM states SHALL be IDLE and WAIT.
REQ-008 IDLE with IRWrite=1 SHALL go to WAIT and latch the current (pre-update) pc into an address register; a same-cycle pc_we does not affect the latched address.
REQ-009 In WAIT: imem_req=1, and imem_addr SHALL be the latched address, held stable until ack.
REQ-010 In WAIT with imem_ack=1: ir <= imem_rdata, fetch_done=1 in the next cycle, return to IDLE.
REQ-011 Latency: IRWrite in cycle n, imem_req in n+1, ack in n+k (k>=1), new ir and fetch_done in n+k+1.
REQ-012 IRWrite while in WAIT SHALL be ignored (no queuing); imem_ack while in IDLE SHALL be ignored.
REQ-013 Outside WAIT: imem_req=0; imem_addr shows the latched address.
REQ-014 opcode and func_field SHALL be combinational slices of ir.

Reset
REQ-015 rst=0 SHALL immediately force: pc=RESET_PC; ir=16'h0000; address register=RESET_PC; state=IDLE; imem_req, fetch_busy, fetch_done, fetch_err=0; timeout counter=0.
REQ-016 Reset during WAIT SHALL abandon the fetch; a late ack after reset release is ignored per REQ-012.

Configuration
REQ-017 With macro FETCH_TIMEOUT_EN defined: an 8-bit counter runs in WAIT. If TIMEOUT_CYCLES WAIT cycles pass without ack, the block SHALL load ir=16'h0000 (opcode 0000 / func 0000, treated as a NOP by the controller), pulse fetch_done and fetch_err in the next cycle, and return to IDLE. An ack in the final counted cycle SHALL win over the timeout.
REQ-018 Without FETCH_TIMEOUT_EN: WAIT lasts indefinitely, no counter is synthesised, and fetch_err is tied to 0.

Structure
REQ-019 Shared package fetch_pkg SHALL hold: the PCSrc encodings (PCSRC_ALU=2'b00, PCSRC_JMP=2'b01); the state encoding; the NOP constant 16'h0000.
REQ-020 PC register plus next-PC mux SHALL be a sub-module pc_reg; FSM, IR and timeout logic stay in fetch_unit.

Verification
REQ-021 Reset release, then IRWrite pulse, imem_rdata=16'h8123 with ack after 3 cycles -> imem_addr=0000 throughout WAIT, ir=8123, opcode=8, func_field=3, one fetch_done pulse.
REQ-022 pc=0010, PCBEqCond=1, alu_zero=1, PCSrc=00, alu_result=0044 -> pc=0044; repeat with alu_zero=0 -> pc unchanged; repeat with PCBNqCond=1 and alu_zero=0 -> pc=0044.
REQ-023 pc=3000, ir=3ABC, PCWrite=1, PCSrc=01 -> pc=3ABC; PCSrc=10 with PCWrite=1 -> pc unchanged.
REQ-024 IRWrite and PCWrite (alu_result=0002) in the same cycle with pc=0000 -> imem_addr=0000, pc=0002; a second IRWrite during WAIT -> no extra request.
REQ-025 With FETCH_TIMEOUT_EN and no ack -> after 15 WAIT cycles: ir=0000, fetch_done and fetch_err pulse, state IDLE; ack in cycle 15 -> data loaded and fetch_err=0.
REQ-026 rst=0 asserted mid-WAIT -> imem_req drops immediately, pc=RESET_PC; ack after release -> ir stays 0000.
